// File: rtl/mod_counter_ctrl_pkg.sv
// Shared state encoding and limits for the mod-N counter controller.
package mod_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Smallest modulus that still produces a real count sequence.
  localparam int MIN_MOD = 2;

endpackage

// File: rtl/mod_counter_core.sv
// Embedded mod-N up-counter: counts 0..mod-1 while enabled, flags the wrap.
module mod_counter_core #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] mod,
  output logic [W-1:0] cnt_q,
  output logic         wrap
);

  // Terminal-count compare; the controller only enables with mod >= 2.
  assign wrap = en && (cnt_q == (mod - W'(1)));

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : (cnt_q + W'(1));
    end
  end

endmodule

// File: rtl/mod_counter_ctrl.sv
// Configures, sequences and monitors the mod-N counter core.
//
// state | meaning
// IDLE  | no valid config held
// ARMED | config held, not counting
// RUN   | counting
// DONE  | one-shot run finished, config still held
module mod_counter_ctrl
  import mod_counter_ctrl_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_mod,
  input  logic         cfg_oneshot,
  input  logic         start,
  input  logic         stop,
  output logic [W-1:0] cnt_q,
  output logic         tick,
  output logic         done,
  output logic         busy,
  output logic         err
);

  state_e       state_q;
  logic [W-1:0] mod_q;
  logic         oneshot_q;
  logic         core_clr;
  logic         core_en;
  logic         wrap;

  // Config is held off (not dropped) while counting.
  assign cfg_ready = (state_q != RUN);

  // Counter sits at zero outside RUN, so entering RUN always starts from 0;
  // stop clears it on the same edge and suppresses any wrap.
  assign core_clr = (state_q != RUN) || stop;
  assign core_en  = (state_q == RUN) && !stop;

  mod_counter_core #(.W(W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (core_clr),
    .en    (core_en),
    .mod   (mod_q),
    .cnt_q (cnt_q),
    .wrap  (wrap)
  );

  // Control FSM with registered flags; priority is stop > start > cfg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mod_q     <= '0;
      oneshot_q <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tick <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        RUN: begin
          if (stop) begin
            state_q <= ARMED;
            busy    <= 1'b0;
          end else if (wrap) begin
            tick <= 1'b1;
            if (oneshot_q) begin
              state_q <= DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          if (start && !stop) begin
            if (state_q == IDLE) begin
              err <= 1'b1;
            end else begin
              state_q <= RUN;
              busy    <= 1'b1;
              done    <= 1'b0;
            end
          end else if (cfg_valid) begin
            if (cfg_mod >= W'(MIN_MOD)) begin
              mod_q     <= cfg_mod;
              oneshot_q <= cfg_oneshot;
              state_q   <= ARMED;
              done      <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_counter_ctrl.sv
module tb_mod_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_mod = 4'd0;
  logic       cfg_oneshot = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] cnt_q;
  logic       tick, done, busy, err;

  mod_counter_ctrl #(.W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mod     (cfg_mod),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .cnt_q       (cnt_q),
    .tick        (tick),
    .done        (done),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  // expected = {cnt[3:0], tick, done, busy, err, cfg_ready}
  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [8:0] E(input int c, input bit t, input bit d,
                                   input bit b, input bit e, input bit r);
    logic [3:0] c4;
    c4 = 4'(c);
    return {c4, t, d, b, e, r};
  endfunction

  // Apply one cycle of inputs (at negedge) and queue the expected outputs
  // that the DUT should show after the next posedge.
  task automatic step(input string tag, input logic r, input logic cv,
                      input logic [3:0] cm, input logic co, input logic st,
                      input logic sp, input logic [8:0] e);
    exp_t x;
    @(negedge clk);
    rst = r; cfg_valid = cv; cfg_mod = cm; cfg_oneshot = co;
    start = st; stop = sp;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic idle(input string tag, input logic [8:0] e);
    step(tag, 0, 0, 4'd0, 0, 0, 0, e);
  endtask

  // Monitor: compare every queued expectation one step after its edge.
  initial begin
    exp_t       x;
    logic [8:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        act = {cnt_q, tick, done, busy, err, cfg_ready};
        n_vec++;
        if (act !== x.exp) begin
          n_bad++;
          $display("FAIL %s: got cnt=%0d tick=%b done=%b busy=%b err=%b rdy=%b, want cnt=%0d tick=%b done=%b busy=%b err=%b rdy=%b",
                   x.tag, act[8:5], act[4], act[3], act[2], act[1], act[0],
                   x.exp[8:5], x.exp[4], x.exp[3], x.exp[2], x.exp[1], x.exp[0]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    step("reset0", 1, 0, 4'd0, 0, 0, 0, E(0,0,0,0,0,1));
    step("reset1", 1, 0, 4'd0, 0, 0, 0, E(0,0,0,0,0,1));

    // Illegal requests in IDLE
    step("cfg1_idle_err", 0, 1, 4'd1, 0, 0, 0, E(0,0,0,0,1,1));
    idle("err_clears",                     E(0,0,0,0,0,1));
    step("start_idle_err", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,0,1,1));
    idle("err_clears2",                    E(0,0,0,0,0,1));

    // Periodic mod 4
    step("cfg4_periodic", 0, 1, 4'd4, 0, 0, 0, E(0,0,0,0,0,1));
    step("start4", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    for (int i = 1; i <= 9; i++)
      idle("run4", E(i % 4, (i % 4) == 0, 0, 1, 0, 0));
    step("stop4", 0, 0, 4'd0, 0, 0, 1, E(0,0,0,0,0,1));

    // Illegal cfg in ARMED keeps mod 4
    step("cfg0_armed_err", 0, 1, 4'd0, 0, 0, 0, E(0,0,0,0,1,1));
    step("restart4", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    for (int i = 1; i <= 4; i++)
      idle("mod_retained", E(i % 4, (i % 4) == 0, 0, 1, 0, 0));
    step("stop4b", 0, 0, 4'd0, 0, 0, 1, E(0,0,0,0,0,1));

    // One-shot mod 3
    step("cfg3_oneshot", 0, 1, 4'd3, 1, 0, 0, E(0,0,0,0,0,1));
    step("start3", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    idle("os_c1",   E(1,0,0,1,0,0));
    idle("os_c2",   E(2,0,0,1,0,0));
    idle("os_wrap", E(0,1,1,0,0,1));
    idle("os_done", E(0,0,1,0,0,1));
    idle("os_hold", E(0,0,1,0,0,1));
    step("os_restart", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    idle("os2_c1",   E(1,0,0,1,0,0));
    idle("os2_c2",   E(2,0,0,1,0,0));
    idle("os2_wrap", E(0,1,1,0,0,1));
    idle("os2_done", E(0,0,1,0,0,1));

    // Stop exactly at the wrap cycle, mod 5
    step("cfg5_from_done", 0, 1, 4'd5, 0, 0, 0, E(0,0,0,0,0,1));
    step("start5", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    for (int i = 1; i <= 4; i++)
      idle("run5", E(i, 0, 0, 1, 0, 0));
    step("stop_at_wrap", 0, 0, 4'd0, 0, 0, 1, E(0,0,0,0,0,1));
    step("start_stop_armed", 0, 0, 4'd0, 0, 1, 1, E(0,0,0,0,0,1));
    idle("still_armed", E(0,0,0,0,0,1));
    step("start_from_armed", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    step("stop5", 0, 0, 4'd0, 0, 0, 1, E(0,0,0,0,0,1));

    // Config held off during RUN
    step("cfg4_again", 0, 1, 4'd4, 0, 0, 0, E(0,0,0,0,0,1));
    step("start4c", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    for (int i = 1; i <= 8; i++)
      step("cfg7_held_off", 0, 1, 4'd7, 0, 0, 0, E(i % 4, (i % 4) == 0, 0, 1, 0, 0));
    step("stop_with_cfg", 0, 1, 4'd7, 0, 0, 1, E(0,0,0,0,0,1));
    step("cfg7_accept", 0, 1, 4'd7, 0, 0, 0, E(0,0,0,0,0,1));
    step("start7", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    for (int i = 1; i <= 8; i++)
      idle("run7", E(i % 7, (i % 7) == 0, 0, 1, 0, 0));
    step("stop7", 0, 0, 4'd0, 0, 0, 1, E(0,0,0,0,0,1));

    // Reset mid-run, mod 15
    step("cfg15", 0, 1, 4'd15, 0, 0, 0, E(0,0,0,0,0,1));
    step("start15", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,1,0,0));
    for (int i = 1; i <= 9; i++)
      idle("run15", E(i, 0, 0, 1, 0, 0));
    step("rst_midrun", 1, 0, 4'd0, 0, 0, 0, E(0,0,0,0,0,1));
    step("start_after_rst", 0, 0, 4'd0, 0, 1, 0, E(0,0,0,0,1,1));
    idle("final_idle", E(0,0,0,0,0,1));

    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_counter_ctrl.md
Name: mod_counter_ctrl

Overview:
Controller that configures, sequences and monitors an embedded mod-N up-counter. Requesters write a modulus and mode over a valid/ready config port, then start and stop the count. The block emits a one-cycle tick on every wrap and a done flag in one-shot mode. It sits between software-style control logic and any block that needs a programmable periodic or single timing pulse.

Parameters:
W, 4, width of counter value and modulus; legal modulus range 2..2^W-1

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  config request
cfg_ready  output  1  config can be accepted this cycle
cfg_mod  input  W  modulus N (counter counts 0..N-1)
cfg_oneshot  input  1  1 = stop after first wrap, 0 = periodic
start  input  1  begin counting (level sampled each clock)
stop  input  1  abort counting (level sampled each clock)
cnt_q  output  W  current counter value
tick  output  1  one-cycle pulse on each wrap
done  output  1  level; one-shot run completed
busy  output  1  high while in RUN
err  output  1  one-cycle pulse on illegal request

Behaviour:
- Reset values (next posedge with rst=1, from any state, including mid-run): state IDLE; cnt_q=0; mod_reg=0; oneshot_reg=0; tick=0; done=0; busy=0; err=0; cfg_ready=1.
- States:
  - IDLE: no valid config.
  - ARMED: config held, not counting.
  - RUN: counting.
  - DONE: one-shot finished.
- cfg_ready is 1 in IDLE, ARMED and DONE, and 0 in RUN. It is combinational from state.
- Config handshake:
  - The handshake completes when cfg_valid and cfg_ready are both 1.
  - If cfg_mod >= 2: latch mod_reg and oneshot_reg; go to ARMED; clear done.
  - If cfg_mod is 0 or 1: err=1 for one cycle. State, mod_reg and done are unchanged.
  - cfg_valid while in RUN is held off, not dropped and not flagged.
- start:
  - In ARMED or DONE: go to RUN at that edge; cnt_q=0; busy=1; done=0.
  - In IDLE: err pulse; stay in IDLE.
  - In RUN: ignored.
- RUN counting:
  - Each edge: if cnt_q == mod_reg-1, then cnt_q<=0 and tick<=1; otherwise cnt_q<=cnt_q+1 and tick<=0.
  - tick is registered. It is high in the same cycle that cnt_q shows 0 after a wrap.
  - Tick period is exactly N cycles. The first tick appears N edges after the edge that sampled start.
  - Compare with == only. mod_reg >= 2, so no overflow is possible.
- One-shot: on the wrap edge go to DONE with cnt_q=0, tick=1 (one cycle), done=1 (held), busy=0.
- Periodic: stay in RUN indefinitely until stop or rst.
- stop:
  - In RUN: go to ARMED; cnt_q=0; busy=0; no tick, even if the same edge would have wrapped.
  - In other states: ignored, no err.
- Priority in the same cycle: rst > stop > start > cfg. start+stop in ARMED means stay in ARMED. start and cfg in ARMED/DONE means start wins and cfg is not accepted (cfg_ready is deasserted as the state moves to RUN, so the handshake is retried).
- err: registered, one-cycle pulse, never held.
- All outputs are registered except cfg_ready.

Decomposition:
- Package mod_counter_ctrl_pkg: state encoding constants (IDLE=2'd0, ARMED=2'd1, RUN=2'd2, DONE=2'd3) and MIN_MOD=2.
- One natural sub-module, mod_counter_core: holds cnt_q; inputs clr, en, mod; outputs wrap. Same synchronous active-high reset.
- The FSM, handshake and flags stay in the top level.

Test Plan:
- Reset then periodic run: cfg_mod=4, cfg_oneshot=0 handshake, start pulse -> cnt_q 0,1,2,3,0,1,...; tick high exactly when cnt_q returns to 0 (every 4 cycles, first tick 4 edges after start); busy=1 throughout.
- One-shot: cfg_mod=3, cfg_oneshot=1, start -> cnt_q 0,1,2,0; single tick; state DONE with done=1, busy=0; a second start restarts with done cleared and a tick after 3 more cycles.
- Illegal requests: cfg_mod=1 in IDLE -> err pulse, cfg_ready stays 1, state IDLE; start in IDLE -> err pulse; cfg_mod=0 in ARMED -> err pulse, old mod_reg retained.
- Stop at wrap: mod=5 periodic, assert stop in the cycle cnt_q=4 -> next cnt_q=0, tick=0, busy=0, state ARMED; start+stop together in ARMED -> remain in ARMED.
- Config during RUN: cfg_valid=1 with cfg_mod=7 while running mod=4 -> cfg_ready=0 and the period stays 4; after stop, the handshake completes on the next cycle and the following run ticks every 7 cycles.
- Reset mid-run: mod=15 periodic, assert rst at cnt_q=9 -> next edge cnt_q=0, tick=0, busy=0, cfg_ready=1, state IDLE; start then gives err.
